// File: rtl/object_pkg.sv
// rtl/object_pkg.sv - shared object payload type and scheduler state encoding
package object_pkg;
    localparam int OBJ_W = 16;

    typedef logic [OBJ_W-1:0] object_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REWIND,
        ST_DRAIN
    } obj_sched_state_t;
endpackage

// File: rtl/object_scheduler_rr_arbiter.sv
// rtl/object_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with rotating priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                // Priority rotates to the source just after the winner
                ptr_d    = PW'((int'(ptr_q) + off + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/object_scheduler.sv
// rtl/object_scheduler.sv - frame object collector/drainer; OBJECT_SCHED_DROP_EN enables drop-on-full
module object_scheduler
    import object_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SIZE  = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*OBJ_W-1:0] src_data,
    output logic [N_SRC-1:0]       src_ready,
    output logic [OBJ_W-1:0]       buf_data_a,
    output logic                   buf_write_a,
    output logic                   buf_next_frame,
    output logic                   buf_read_b,
    input  logic [OBJ_W-1:0]       buf_data_b,
    input  logic                   buf_full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OBJ_W-1:0]       out_data,
    output logic                   out_last,
`ifdef OBJECT_SCHED_DROP_EN
    output logic [15:0]            drop_count,
`endif
    output logic                   overrun
);
    localparam int            CW     = $clog2(SIZE + 1);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

    obj_sched_state_t state_q, state_d;
    logic [CW-1:0]    wr_total_q, wr_total_d;
    logic [CW-1:0]    rd_count_q, rd_count_d;
    logic             full;
    logic             arb_en;

    assign full     = buf_full || (wr_total_q == SIZE_C);
    assign out_data = buf_data_b;

`ifdef OBJECT_SCHED_DROP_EN
    logic [15:0] drop_count_q, drop_count_d;

    // Granting continues while full so producers never stall; the write is suppressed
    assign arb_en     = (state_q == ST_COLLECT);
    assign drop_count = drop_count_q;

    always_comb begin
        drop_count_d = drop_count_q;
        if ((|src_ready) && full && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end
`else
    assign arb_en = (state_q == ST_COLLECT) && !full;
`endif

    rr_arbiter #(.N(N_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (src_valid),
        .en  (arb_en),
        .gnt (src_ready)
    );

    always_comb begin
        state_d        = state_q;
        wr_total_d     = wr_total_q;
        rd_count_d     = rd_count_q;
        buf_write_a    = 1'b0;
        buf_data_a     = '0;
        buf_next_frame = 1'b0;
        buf_read_b     = 1'b0;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        overrun        = frame_start && (state_q != ST_IDLE);

        for (int i = 0; i < N_SRC; i++) begin
            if (src_ready[i] && !full) begin
                buf_write_a = 1'b1;
                buf_data_a  = src_data[i*OBJ_W +: OBJ_W];
            end
        end
        if (buf_write_a && (wr_total_q != SIZE_C)) begin
            wr_total_d = wr_total_q + CW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (frame_end) state_d = ST_REWIND;
            end
            ST_REWIND: begin
                buf_next_frame = 1'b1;
                state_d        = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid  = rd_count_q < wr_total_q;
                out_last   = out_valid && (rd_count_q == wr_total_q - CW'(1));
                buf_read_b = out_valid && out_ready;
                rd_count_d = rd_count_q + CW'(buf_read_b);
                // Leave as soon as the final handshake lands; empty buffer exits at once
                if (rd_count_d == wr_total_q) begin
                    state_d    = ST_IDLE;
                    rd_count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_total_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_total_q <= wr_total_d;
            rd_count_q <= rd_count_d;
        end
    end
endmodule

// File: doc/object_scheduler.md
# object_scheduler

Front-end controller for the per-frame object buffer. Arbitrates up to N_SRC object producers onto the buffer's single write port with round-robin fairness during a frame. At frame end it rewinds the buffer read cursor and drains all stored objects to a valid/ready output stream with a last marker. Sits between the detection units and the buffer; the downstream consumer is overlay or readout.

## Interface
- N_SRC, 4, number of producers (≥2)
- SIZE, 50, buffer depth; must match the buffer instance
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse, frame begins
- frame_end  in  1  one-cycle pulse, frame object collection ends
- src_valid  in  N_SRC  producer i has an object
- src_data  in  N_SRC × object_t  producer payloads
- src_ready  out  N_SRC  one-hot grant; object i accepted this cycle
- buf_data_a  out  object_t  write data to buffer
- buf_write_a  out  1  buffer write strobe
- buf_next_frame  out  1  buffer read-cursor rewind pulse
- buf_read_b  out  1  buffer read-advance strobe
- buf_data_b  in  object_t  buffer read data at read cursor (combinational)
- buf_full  in  1  buffer full flag
- out_valid / out_ready  out / in  1 / 1  drain stream handshake
- out_data  out  object_t  equals buf_data_b
- out_last  out  1  marks final drained object
- overrun  out  1  one-cycle pulse: frame_start received outside IDLE

## Operation
- States: IDLE, COLLECT, REWIND, DRAIN.
- IDLE: frame_start → COLLECT. frame_end is ignored.
- COLLECT: round-robin grant among src_valid, one per cycle, while not full. Full = buf_full or wr_total == SIZE. Grant asserts src_ready[i], buf_write_a, and buf_data_a = src_data[i]. The RR pointer moves to i+1 mod N_SRC after a grant and holds otherwise. frame_end → REWIND; a grant in the same cycle still completes.
- REWIND: buf_next_frame = 1 for exactly one cycle → DRAIN. No grants.
- DRAIN: out_valid = (rd_count < wr_total). buf_read_b = out_valid & out_ready; rd_count increments on each handshake. out_last = out_valid & (rd_count == wr_total−1). When rd_count == wr_total → IDLE, with rd_count cleared. Empty buffer: DRAIN lasts one cycle with no out_valid.
- wr_total counts all writes since reset and mirrors the buffer write cursor. It saturates at SIZE and is width $clog2(SIZE+1). Buffer contents persist across frames; each drain replays every object stored since reset.
- frame_start in COLLECT, REWIND or DRAIN: ignored, overrun pulses.
- frame_start and frame_end in the same cycle in IDLE: start wins → COLLECT.
- Reset mid-operation: immediate return to IDLE. Counters and RR pointer go to 0.

## Timing
- Reset values: src_ready 0, buf_write_a 0, buf_next_frame 0, buf_read_b 0, out_valid 0, out_last 0, overrun 0, buf_data_a all-zero. State IDLE, counters 0.
- Grant is combinational from src_valid, state, full and RR pointer. The write lands on the next edge.
- frame_end at edge k: REWIND during cycle k+1, first out_valid at cycle k+2.
- Drain throughput: one object per cycle while out_ready is high. out_data is stable while out_valid & !out_ready.

## Configuration
- OBJECT_SCHED_DROP_EN defined: when full in COLLECT, the arbiter still grants (src_ready high) but suppresses buf_write_a, so the object is discarded. A 16-bit saturating output drop_count increments per discarded object and clears on reset only.
- Undefined: full yields src_ready all-zero (backpressure); no drop_count port.

## Structure
- Package object_pkg holds the state enum obj_sched_state_t alongside object_t.
- Sub-module rr_arbiter (N parameter): request vector, enable, one-hot grant, rotating pointer.

## Test plan
- Reset then idle: all outputs 0. frame_end alone → state stays IDLE, no buf_next_frame.
- N_SRC=4, all src_valid high for 8 cycles in COLLECT → grants in order 0,1,2,3,0,1,2,3; wr_total = 8.
- frame_end with 3 objects stored, out_ready high → buf_next_frame at k+1. Then out_valid for 3 cycles, out_last on the 3rd only, then IDLE.
- out_ready toggling 1,0,0,1,1 during drain → out_data held across the stall cycles; buf_read_b only on handshake cycles.
- Fill to SIZE=50 with src_valid[0] held high → after 50 writes src_ready = 0 (without macro). With OBJECT_SCHED_DROP_EN, 5 further cycles → drop_count = 5.
- frame_start during DRAIN → overrun pulses one cycle and the drain completes unaffected.
